// File: rtl/alu_issue.sv
// Serialized RV32I ALU issue stage: 32x32 register file, 4-state issue FSM, external ALU.
// Define ALU_ISSUE_ITYPE_EN to accept OP-IMM (0010011) instructions; otherwise they are illegal.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic        alu_en,
    output logic        alu_i,
    output logic [31:0] alu_op0,
    output logic [31:0] alu_op1,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WB} state_t;

    state_t      state_q, state_d;
    logic        alu_en_q, alu_en_d;
    logic        alu_i_q, alu_i_d;
    logic [31:0] op0_q, op0_d;
    logic [31:0] op1_q, op1_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        illegal_q, illegal_d;
    logic        rf_we;
    logic [31:0] rf_q [32];

    // instruction fields
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [31:0] rs1_val, rs2_val;
    logic        is_rtype, is_itype, r_legal, legal;
    logic [31:0] imm;
    logic        op_b;

    assign opc     = instr[6:0];
    assign dec_rd  = instr[11:7];
    assign f3      = instr[14:12];
    assign dec_rs1 = instr[19:15];
    assign dec_rs2 = instr[24:20];
    assign f7      = instr[31:25];

    assign rs1_val = (dec_rs1 == 5'd0) ? 32'd0 : rf_q[dec_rs1];
    assign rs2_val = (dec_rs2 == 5'd0) ? 32'd0 : rf_q[dec_rs2];

    assign is_rtype = (opc == 7'b0110011);
    // funct7=0100000 is only meaningful for SUB and SRA
    assign r_legal  = is_rtype &&
                      ((f7 == 7'b0000000) ||
                       ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));

`ifdef ALU_ISSUE_ITYPE_EN
    assign is_itype = (opc == 7'b0010011);
    assign imm      = {{20{instr[31]}}, instr[31:20]};
`else
    assign is_itype = 1'b0;
    assign imm      = 32'd0;
`endif

    assign legal = r_legal || is_itype;
    assign op_b  = is_itype ? ((f3 == 3'b101) && instr[30]) : f7[5];

    always_comb begin
        state_d    = state_q;
        alu_en_d   = 1'b0;
        alu_i_d    = 1'b0;
        op0_d      = op0_q;
        op1_d      = op1_q;
        opcode_d   = opcode_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        illegal_d  = 1'b0;
        rf_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    if (legal) begin
                        state_d  = ISSUE;
                        alu_en_d = 1'b1;
                        alu_i_d  = 1'b1;
                        op0_d    = rs1_val;
                        op1_d    = is_itype ? imm : rs2_val;
                        opcode_d = {f3, op_b};
                        rd_d     = dec_rd;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                state_d    = WB;
                rf_we      = (rd_q != 5'd0);
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = (rd_q == 5'd0) ? 32'd0 : alu_result;
            end
            WB: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            alu_en_q   <= 1'b0;
            alu_i_q    <= 1'b0;
            op0_q      <= '0;
            op1_q      <= '0;
            opcode_q   <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            alu_en_q   <= alu_en_d;
            alu_i_q    <= alu_i_d;
            op0_q      <= op0_d;
            op1_q      <= op1_d;
            opcode_q   <= opcode_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
            if (rf_we) rf_q[rd_q] <= alu_result;
        end
    end

    assign instr_ready = (state_q == IDLE) && !rst;
    assign alu_en      = alu_en_q;
    assign alu_i       = alu_i_q;
    assign alu_op0     = op0_q;
    assign alu_op1     = op1_q;
    assign alu_opcode  = opcode_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign illegal     = illegal_q;
    assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU on alu_result.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic        alu_en, alu_i;
    logic [31:0] alu_op0, alu_op1;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int tests = 0;
    int fails = 0;

    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;
    logic [31:0] model;

    int          en_cnt, wb_cyc, rdy_cyc, ill_cnt;
    logic [3:0]  obs_opc;
    logic [31:0] obs_op0, obs_op1, obs_data;
    logic [4:0]  obs_rd;

    alu_issue dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_en(alu_en), .alu_i(alu_i), .alu_op0(alu_op0),
        .alu_op1(alu_op1), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // reference ALU; ovr_en lets the bench load arbitrary values through the writeback path
    always_comb begin
        model = 32'd0;
        case (alu_opcode)
            4'b0000: model = alu_op0 + alu_op1;
            4'b0001: model = alu_op0 - alu_op1;
            4'b0010: model = alu_op0 << alu_op1[4:0];
            4'b0100: model = {31'd0, $signed(alu_op0) < $signed(alu_op1)};
            4'b0110: model = {31'd0, alu_op0 < alu_op1};
            4'b1000: model = alu_op0 ^ alu_op1;
            4'b1010: model = alu_op0 >> alu_op1[4:0];
            4'b1011: model = $unsigned($signed(alu_op0) >>> alu_op1[4:0]);
            4'b1100: model = alu_op0 | alu_op1;
            4'b1110: model = alu_op0 & alu_op1;
            default: model = 32'd0;
        endcase
        alu_result = ovr_en ? ovr_val : model;
    end

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // offers one instruction, then records six cycles of outputs (cycle 1 = first after accept)
    task automatic run_instr(input logic [31:0] ins);
        en_cnt = 0; wb_cyc = 0; rdy_cyc = 0; ill_cnt = 0;
        obs_opc = '0; obs_op0 = '0; obs_op1 = '0; obs_rd = '0; obs_data = '0;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 32'hFFFF_FFFF;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (alu_en) begin
                en_cnt++;
                obs_opc = alu_opcode; obs_op0 = alu_op0; obs_op1 = alu_op1;
            end
            if (wb_valid) begin
                wb_cyc = c; obs_rd = wb_rd; obs_data = wb_data;
            end
            if (illegal) ill_cnt++;
            if (instr_ready && rdy_cyc == 0) rdy_cyc = c;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if ({alu_en, alu_i, wb_valid, illegal} !== 4'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 0000", {alu_en, alu_i, wb_valid, illegal});
        end
        tests++; if ({alu_op0, alu_op1, wb_data, wb_rd, alu_opcode} !== '0) begin
            fails++; $display("FAIL reset_data: got %h/%h/%h/%h/%h expected 0", alu_op0, alu_op1, wb_data, wb_rd, alu_opcode);
        end
        rst = 1'b0;
        #1;
        tests++; if (instr_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b expected 1", instr_ready);
        end
        dbg_addr = 5'd5; #1;
        tests++; if (dbg_data !== 32'd0) begin
            fails++; $display("FAIL reset_rf: got %h expected 0", dbg_data);
        end
    endtask

    task automatic test_load;
`ifdef ALU_ISSUE_ITYPE_EN
        run_instr(32'h0050_0093);
        tests++; if (en_cnt !== 1 || obs_opc !== 4'b0000 || obs_op1 !== 32'd5) begin
            fails++; $display("FAIL addi_x1_issue: got en=%0d opc=%b op1=%h expected 1/0000/5", en_cnt, obs_opc, obs_op1);
        end
        run_instr(32'hFFD0_0113);
        tests++; if (en_cnt !== 1 || obs_opc !== 4'b0000 || obs_op1 !== 32'hFFFF_FFFD) begin
            fails++; $display("FAIL addi_x2_issue: got en=%0d opc=%b op1=%h expected 1/0000/fffffffd", en_cnt, obs_opc, obs_op1);
        end
`else
        run_instr(32'h0050_0093);
        tests++; if (ill_cnt !== 1 || en_cnt !== 0) begin
            fails++; $display("FAIL itype_disabled: got ill=%0d en=%0d expected 1/0", ill_cnt, en_cnt);
        end
        ovr_en = 1'b1;
        ovr_val = 32'd5;          run_instr(rtype(7'd0, 5'd0, 5'd0, 3'b000, 5'd1));
        ovr_val = 32'hFFFF_FFFD;  run_instr(rtype(7'd0, 5'd0, 5'd0, 3'b000, 5'd2));
        ovr_en = 1'b0;
`endif
        dbg_addr = 5'd1; #1;
        tests++; if (dbg_data !== 32'd5) begin
            fails++; $display("FAIL load_x1: got %h expected 00000005", dbg_data);
        end
        dbg_addr = 5'd2; #1;
        tests++; if (dbg_data !== 32'hFFFF_FFFD) begin
            fails++; $display("FAIL load_x2: got %h expected fffffffd", dbg_data);
        end
    endtask

    task automatic test_sub;
        run_instr(rtype(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3));
        tests++; if (en_cnt !== 1 || obs_opc !== 4'b0001 || obs_op0 !== 32'd5 || obs_op1 !== 32'hFFFF_FFFD) begin
            fails++; $display("FAIL sub_issue: got en=%0d opc=%b op0=%h op1=%h expected 1/0001/5/fffffffd", en_cnt, obs_opc, obs_op0, obs_op1);
        end
        tests++; if (wb_cyc !== 3 || obs_rd !== 5'd3 || obs_data !== 32'd8) begin
            fails++; $display("FAIL sub_wb: got cyc=%0d rd=%0d data=%h expected 3/3/8", wb_cyc, obs_rd, obs_data);
        end
        tests++; if (rdy_cyc !== 4) begin
            fails++; $display("FAIL sub_latency: got ready at %0d expected 4", rdy_cyc);
        end
        dbg_addr = 5'd3; #1;
        tests++; if (dbg_data !== 32'd8) begin
            fails++; $display("FAIL sub_x3: got %h expected 00000008", dbg_data);
        end
    endtask

    task automatic test_compare;
        run_instr(rtype(7'd0, 5'd1, 5'd2, 3'b010, 5'd5));
        dbg_addr = 5'd5; #1;
        tests++; if (obs_opc !== 4'b0100 || dbg_data !== 32'd1) begin
            fails++; $display("FAIL slt: got opc=%b x5=%h expected 0100/1", obs_opc, dbg_data);
        end
        run_instr(rtype(7'd0, 5'd1, 5'd2, 3'b011, 5'd6));
        dbg_addr = 5'd6; #1;
        tests++; if (obs_opc !== 4'b0110 || dbg_data !== 32'd0 || wb_cyc !== 3) begin
            fails++; $display("FAIL sltu: got opc=%b x6=%h wb=%0d expected 0110/0/3", obs_opc, dbg_data, wb_cyc);
        end
    endtask

    task automatic test_shift;
`ifdef ALU_ISSUE_ITYPE_EN
        run_instr({7'b0100000, 5'd1, 5'd2, 3'b101, 5'd4, 7'b0010011});
`else
        run_instr(rtype(7'b0100000, 5'd5, 5'd2, 3'b101, 5'd4));
`endif
        dbg_addr = 5'd4; #1;
        tests++; if (obs_opc !== 4'b1011 || obs_op1[4:0] !== 5'd1 || dbg_data !== 32'hFFFF_FFFE) begin
            fails++; $display("FAIL sra: got opc=%b sh=%0d x4=%h expected 1011/1/fffffffe", obs_opc, obs_op1[4:0], dbg_data);
        end
    endtask

    task automatic test_x0;
        run_instr(rtype(7'd0, 5'd1, 5'd1, 3'b000, 5'd0));
        tests++; if (wb_cyc !== 3 || obs_rd !== 5'd0 || obs_data !== 32'd0) begin
            fails++; $display("FAIL x0_wb: got cyc=%0d rd=%0d data=%h expected 3/0/0", wb_cyc, obs_rd, obs_data);
        end
        dbg_addr = 5'd0; #1;
        tests++; if (dbg_data !== 32'd0) begin
            fails++; $display("FAIL x0_read: got %h expected 0", dbg_data);
        end
    endtask

    task automatic test_illegal;
        run_instr(32'hFFFF_FFFF);
        tests++; if (ill_cnt !== 1 || en_cnt !== 0 || rdy_cyc !== 1 || wb_cyc !== 0) begin
            fails++; $display("FAIL illegal_ones: got ill=%0d en=%0d rdy=%0d wb=%0d expected 1/0/1/0", ill_cnt, en_cnt, rdy_cyc, wb_cyc);
        end
        run_instr(rtype(7'b0100000, 5'd1, 5'd1, 3'b001, 5'd9));
        tests++; if (ill_cnt !== 1 || en_cnt !== 0) begin
            fails++; $display("FAIL illegal_f7_sll: got ill=%0d en=%0d expected 1/0", ill_cnt, en_cnt);
        end
        run_instr(rtype(7'b0000001, 5'd1, 5'd1, 3'b000, 5'd9));
        tests++; if (ill_cnt !== 1 || en_cnt !== 0) begin
            fails++; $display("FAIL illegal_mul: got ill=%0d en=%0d expected 1/0", ill_cnt, en_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        @(negedge clk);
        instr = rtype(7'd0, 5'd1, 5'd1, 3'b000, 5'd7);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(negedge clk);
        tests++; if (alu_en !== 1'b1 || alu_i !== 1'b1) begin
            fails++; $display("FAIL mid_issue: got en=%b i=%b expected 1/1", alu_en, alu_i);
        end
        @(negedge clk);
        rst = 1'b1; #1;
        tests++; if ({alu_en, alu_i, wb_valid, illegal, alu_op0, alu_op1, alu_opcode, wb_rd, wb_data} !== '0) begin
            fails++; $display("FAIL mid_outputs: got op0=%h op1=%h opc=%b wb=%b expected 0", alu_op0, alu_op1, alu_opcode, wb_valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; #1;
        tests++; if (instr_ready !== 1'b1) begin
            fails++; $display("FAIL mid_idle: got ready=%b expected 1", instr_ready);
        end
        dbg_addr = 5'd7; #1;
        tests++; if (dbg_data !== 32'd0) begin
            fails++; $display("FAIL mid_x7: got %h expected 0", dbg_data);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (wb_valid || alu_en || !instr_ready) bad++;
        end
        tests++; if (bad !== 0) begin
            fails++; $display("FAIL mid_quiet: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        int acc, ens;
        acc = 0; ens = 0;
        @(negedge clk);
        instr = rtype(7'd0, 5'd0, 5'd0, 3'b000, 5'd1);
        instr_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (instr_ready) acc++;
            if (alu_en) ens++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        tests++; if (acc !== 4 || ens !== 4) begin
            fails++; $display("FAIL back_to_back: got accepts=%0d en=%0d expected 4/4", acc, ens);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_load;
        test_sub;
        test_compare;
        test_shift;
        test_x0;
        test_illegal;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
